// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the arbitrated single-port RAM.
package ram_arb_pkg;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic int calc_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ram_s1p1c.sv
// Single-port, single-clock RAM with read-first registered output.
module ram_s1p1c #(
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [WORD_COUNT];
    logic [WORD_WIDTH-1:0] rdata_q;

    // A write cycle still returns the word as it was before the write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_s1p1c_arb.sv
// Round-robin arbiter with per-requester locking in front of one single-port RAM.
module ram_s1p1c_arb
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
    localparam int ID_WIDTH   = calc_id_width(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ-1:0]                   req_lock_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [ID_WIDTH-1:0]                  rsp_id_o,
    output logic [WORD_WIDTH-1:0]                rsp_data_o
);

    lock_state_e           state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
    logic [ID_WIDTH-1:0]   id_hold_q, id_hold_d;
    logic [WORD_WIDTH-1:0] data_hold_q, data_hold_d;

    logic                  gnt_any;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [ID_WIDTH:0]     cand_sum;
    logic                  beat_acc;
    logic                  rsp_fire;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_WIDTH-1:0] ram_wdata;
    logic [WORD_WIDTH-1:0] ram_rdata;

    // Grant selection: the lock owner exclusively, otherwise first valid at/after ptr.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        if (state_q == LOCK_HELD) begin
            gnt_any = req_valid_i[owner_q];
            gnt_idx = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
                if (cand_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                    cand_sum = cand_sum - (ID_WIDTH+1)'(NUM_REQ);
                end
                if (!gnt_any && req_valid_i[cand_sum[ID_WIDTH-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand_sum[ID_WIDTH-1:0];
                end
            end
        end
    end

    assign beat_acc = gnt_any && rstn_i;

    always_comb begin
        req_ready_o = '0;
        if (beat_acc) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign ram_we    = beat_acc && req_we_i[gnt_idx];
    assign ram_addr  = req_addr_i[gnt_idx];
    assign ram_wdata = req_data_i[gnt_idx];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (beat_acc) begin
            ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        if (state_q == LOCK_HELD) begin
            if (!req_valid_i[owner_q] || (beat_acc && !req_lock_i[owner_q])) begin
                state_d = LOCK_IDLE;
            end
        end else if (beat_acc && req_lock_i[gnt_idx]) begin
            state_d = LOCK_HELD;
            owner_d = gnt_idx;
        end
    end

    // A pending response is suppressed immediately if reset arrives in its cycle.
    assign rsp_fire = rsp_vld_q && rstn_i;

    always_comb begin
        rsp_vld_d   = beat_acc && !req_we_i[gnt_idx];
        pend_id_d   = rsp_vld_d ? gnt_idx : pend_id_q;
        id_hold_d   = rsp_fire ? pend_id_q : id_hold_q;
        data_hold_d = rsp_fire ? ram_rdata : data_hold_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= LOCK_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            rsp_vld_q   <= 1'b0;
            pend_id_q   <= '0;
            id_hold_q   <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            rsp_vld_q   <= rsp_vld_d;
            pend_id_q   <= pend_id_d;
            id_hold_q   <= id_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_fire) begin
            rsp_valid_o[pend_id_q] = 1'b1;
        end
    end

    assign rsp_id_o   = rsp_fire ? pend_id_q : id_hold_q;
    assign rsp_data_o = rsp_fire ? ram_rdata : data_hold_q;

    ram_s1p1c #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(req_ready_o));

    a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(rsp_valid_o));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_asrt
        a_valid_hold: assert property (@(posedge clk_i) disable iff (!rstn_i)
            (req_valid_i[i] && !req_ready_o[i]) |=> req_valid_i[i]);
        a_addr_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
            req_valid_i[i] |-> !$isunknown(req_addr_i[i]));
    end

endmodule

// File: tb/tb_ram_s1p1c_arb.sv
// Bench for ram_s1p1c_arb: directed scenarios plus random traffic against a behavioural model.
module tb_ram_s1p1c_arb;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [3:0]      valid = '0;
    logic [3:0]      we = '0;
    logic [3:0]      lock = '0;
    logic [3:0][7:0] addr = '0;
    logic [3:0][7:0] wdata = '0;
    logic [3:0]      ready;
    logic [3:0]      rsp_valid;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_mem [256];
    int         m_ptr = 0;
    bit         m_locked = 1'b0;
    int         m_owner = 0;
    bit         m_pend = 1'b0;
    int         m_pid = 0;
    logic [7:0] m_pdata = '0;
    int         m_hid = 0;
    logic [7:0] m_hdata = '0;
    int         d_gnt = -1;
    int         m_gnt = -1;
    logic [7:0] saved;

    ram_s1p1c_arb #(
        .NUM_REQ    (4),
        .WORD_WIDTH (8),
        .WORD_COUNT (256)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_we_i    (we),
        .req_lock_i  (lock),
        .req_addr_i  (addr),
        .req_data_i  (wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!rstn) return -1;
        if (m_locked) return valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < 4; k++) begin
            if (valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic cycle();
        logic [3:0] exp_ready;
        @(negedge clk);
        m_gnt     = model_grant();
        exp_ready = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
        check("ready", ready, exp_ready);
        if (rstn && m_pend) begin
            check("rsp_valid", rsp_valid, 4'b0001 << m_pid);
            check("rsp_id", rsp_id, m_pid);
            check("rsp_data", rsp_data, m_pdata);
        end else begin
            check("rsp_valid_idle", rsp_valid, 0);
            check("rsp_id_hold", rsp_id, m_hid);
            check("rsp_data_hold", rsp_data, m_hdata);
        end
        d_gnt = -1;
        for (int i = 0; i < 4; i++) begin
            if (valid[i] && ready[i]) d_gnt = i;
        end
        @(posedge clk);
        if (!rstn) begin
            m_ptr = 0; m_locked = 1'b0; m_pend = 1'b0;
            m_hid = 0; m_hdata = '0; m_pid = 0;
        end else begin
            if (m_pend) begin
                m_hid = m_pid;
                m_hdata = m_pdata;
            end
            m_pend = 1'b0;
            if (m_locked) begin
                if (!valid[m_owner]) m_locked = 1'b0;
                else if (m_gnt >= 0 && !lock[m_gnt]) m_locked = 1'b0;
            end else if (m_gnt >= 0 && lock[m_gnt]) begin
                m_locked = 1'b1;
                m_owner = m_gnt;
            end
            if (m_gnt >= 0) begin
                m_ptr = (m_gnt + 1) % 4;
                if (we[m_gnt]) begin
                    m_mem[addr[m_gnt]] = wdata[m_gnt];
                end else begin
                    m_pend = 1'b1;
                    m_pid = m_gnt;
                    m_pdata = m_mem[addr[m_gnt]];
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        lock = '0;
        for (int n = 0; n < 16 && valid != 4'b0000; n++) begin
            cycle();
            if (d_gnt >= 0) valid[d_gnt] = 1'b0;
        end
        check("drain", valid, 0);
        cycle();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cycle();
        check("rst_ready", ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        rstn = 1'b1;

        // Requester 2 writes 0xA5 to 0x10 then reads it back
        valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h10; wdata[2] = 8'hA5;
        cycle();
        check("s1_wr_gnt", d_gnt, 2);
        we[2] = 1'b0;
        cycle();
        check("s1_rd_gnt", d_gnt, 2);
        valid = '0;
        check("s1_rsp_valid", rsp_valid, 4'b0100);
        check("s1_rsp_id", rsp_id, 2);
        check("s1_rsp_data", rsp_data, 8'hA5);
        cycle();

        // Fill the whole RAM so every later read has a known expectation
        valid[0] = 1'b1; we[0] = 1'b1;
        for (int a = 0; a < 256; a++) begin
            addr[0] = 8'(a);
            wdata[0] = 8'($urandom);
            cycle();
        end
        valid = '0; we = '0;
        cycle();

        // Back-to-back write then read of 0xFF by requester 0
        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hFF; wdata[0] = 8'h3C;
        cycle();
        check("s6_wr_gnt", d_gnt, 0);
        we[0] = 1'b0;
        cycle();
        valid = '0;
        check("s6_rsp_valid", rsp_valid, 4'b0001);
        check("s6_rsp_data", rsp_data, 8'h3C);
        cycle();

        // Round-robin order from a fresh reset with all four requesters reading
        rstn = 1'b0;
        cycle(); cycle();
        rstn = 1'b1;
        valid = 4'b1111; we = '0;
        for (int i = 0; i < 4; i++) addr[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("s2_rr_order", d_gnt, i % 4);
            if (d_gnt >= 0) addr[d_gnt] = 8'($urandom);
        end
        drain();

        // Requester 1 holds the lock for three beats while 0 and 3 wait
        valid[1] = 1'b1; lock[1] = 1'b1; addr[1] = 8'h21;
        cycle();
        check("s3_gnt1a", d_gnt, 1);
        valid[0] = 1'b1; valid[3] = 1'b1; addr[0] = 8'h30; addr[3] = 8'h33;
        cycle();
        check("s3_gnt1b", d_gnt, 1);
        lock[1] = 1'b0;
        cycle();
        check("s3_gnt1c", d_gnt, 1);
        valid[1] = 1'b0;
        cycle();
        check("s3_gnt3", d_gnt, 3);
        valid[3] = 1'b0;
        cycle();
        check("s3_gnt0", d_gnt, 0);
        valid[0] = 1'b0;
        cycle();

        // Lock owner drops valid: lock released, other requester next cycle
        valid[1] = 1'b1; lock[1] = 1'b1; addr[1] = 8'h44;
        cycle();
        check("s4_gnt1", d_gnt, 1);
        valid[1] = 1'b0; valid[2] = 1'b1; addr[2] = 8'h55;
        cycle();
        check("s4_no_gnt", d_gnt, -1);
        cycle();
        check("s4_gnt2", d_gnt, 2);
        valid[2] = 1'b0; lock = '0;
        cycle();

        // Read accepted, then reset in the response cycle
        valid[0] = 1'b1; addr[0] = 8'h20;
        saved = m_mem[8'h20];
        cycle();
        check("s5_rd_gnt", d_gnt, 0);
        valid = '0;
        rstn = 1'b0;
        #1;
        check("s5_rsp_suppressed", rsp_valid, 0);
        cycle(); cycle();
        rstn = 1'b1;
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) addr[i] = 8'h20;
        cycle();
        check("s5_first_gnt", d_gnt, 0);
        if (d_gnt >= 0) valid[d_gnt] = 1'b0;
        check("s5_ram_kept", rsp_data, saved);
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (d_gnt == i || !valid[i]) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    we[i]    = 1'($urandom_range(0, 1));
                    lock[i]  = ($urandom_range(0, 3) == 0);
                    addr[i]  = 8'($urandom);
                    wdata[i] = 8'($urandom);
                end
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
